// File: rtl/wfg_mon_pkg.sv
// Shared types for the WFG checkpoint monitor: FSM state encoding and the
// fail_code values reported on the fail_code output.
package wfg_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } mon_state_e;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_TIMEOUT = 2'd1;
  localparam logic [1:0] FC_ORDER   = 2'd2;

endpackage

// File: rtl/wfg_stable_match.sv
// Comparator plus stability counter: o_hit fires on the STABLE_CYCLES-th
// consecutive matching sample, optionally after a forced drop-out of match.
module wfg_stable_match
  import wfg_mon_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int STABLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic             i_clear,
  input  logic             i_rearm,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_hit
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_blocked;
  logic             w_match;
  logic             w_qual;

  assign w_match = (i_a == i_b);
  assign w_qual  = w_match && !r_blocked;
  assign o_hit   = i_run && w_qual && (r_cnt == LAST);

  // A rearm blocks counting until the input has been seen out of match once.
  always_ff @(posedge clk) begin
    if (!rst_n || !i_run) begin
      r_cnt     <= '0;
      r_blocked <= 1'b0;
    end else begin
      if (i_clear || o_hit || !w_qual) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (i_rearm) begin
        r_blocked <= 1'b1;
      end else if (!w_match) begin
        r_blocked <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/wfg_checkpoint_monitor.sv
// Ordered checkpoint sequencer: walks exp_seq step by step on the status bus
// and reports pass, timeout or (optionally) out-of-order failure.
module wfg_checkpoint_monitor
  import wfg_mon_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int NUM_STEPS      = 2,
  parameter int TIMEOUT_CYCLES = 70000,
  parameter int STABLE_CYCLES  = 1,
  parameter int STRICT         = 0,
  localparam int IDX_W         = $clog2(NUM_STEPS + 1),
  localparam int EL_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [WIDTH-1:0]           status,
  input  logic [NUM_STEPS*WIDTH-1:0] exp_seq,
  output logic [IDX_W-1:0]           step_idx,
  output logic                       step_pulse,
  output logic                       pass,
  output logic                       fail,
  output logic [1:0]                 fail_code,
  output logic [EL_W-1:0]            elapsed
);

  mon_state_e       r_state;
  mon_state_e       w_stateNext;
  logic [IDX_W-1:0] r_stepIdx;
  logic [IDX_W-1:0] w_idxNext;
  logic             r_pulse;
  logic             w_pulseNext;
  logic             r_pass;
  logic             w_passNext;
  logic             r_fail;
  logic             w_failNext;
  logic [1:0]       r_failCode;
  logic [1:0]       w_codeNext;
  logic [EL_W-1:0]  r_elapsed;
  logic [EL_W-1:0]  w_elapsedNext;

  logic [WIDTH-1:0] w_codes [NUM_STEPS];
  logic [WIDTH-1:0] w_curCode;
  logic [WIDTH-1:0] w_nextCode;
  logic             w_hasNext;
  logic             w_dupNext;
  logic             w_lastStep;
  logic             w_timeUp;
  logic             w_run;
  logic             w_curHit;
  logic             w_orderHit;

  for (genvar k = 0; k < NUM_STEPS; k++) begin : g_codes
    assign w_codes[k] = exp_seq[k*WIDTH +: WIDTH];
  end

  always_comb begin
    w_curCode  = '0;
    w_nextCode = '0;
    w_hasNext  = 1'b0;
    for (int k = 0; k < NUM_STEPS; k++) begin
      if (r_stepIdx == IDX_W'(k)) begin
        w_curCode = w_codes[k];
      end
      if (r_stepIdx + 1'b1 == IDX_W'(k)) begin
        w_nextCode = w_codes[k];
        w_hasNext  = 1'b1;
      end
    end
  end

  assign w_dupNext  = w_hasNext && (w_nextCode == w_curCode);
  assign w_lastStep = (r_stepIdx == IDX_W'(NUM_STEPS - 1));
  assign w_timeUp   = (r_elapsed >= EL_W'(TIMEOUT_CYCLES - 1));
  assign w_run      = en && (r_state == WAIT);

  wfg_stable_match #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_cur (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_run   (w_run),
    .i_clear (1'b0),
    .i_rearm (w_curHit && w_dupNext),
    .i_a     (status),
    .i_b     (w_curCode),
    .o_hit   (w_curHit)
  );

  // The order checker watches a 1-bit "some later step matches" signal.
  if (STRICT != 0) begin : g_strict
    logic w_laterHit;

    always_comb begin
      w_laterHit = 1'b0;
      for (int k = 0; k < NUM_STEPS; k++) begin
        if ((IDX_W'(k) > r_stepIdx) && (status == w_codes[k])) begin
          w_laterHit = 1'b1;
        end
      end
    end

    wfg_stable_match #(
      .WIDTH         (1),
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_order (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_run   (w_run),
      .i_clear (w_curHit),
      .i_rearm (1'b0),
      .i_a     (w_laterHit),
      .i_b     (1'b1),
      .o_hit   (w_orderHit)
    );
  end else begin : g_lax
    assign w_orderHit = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Event priority in WAIT: final completion > timeout; step completion > order > timeout.
  always_comb begin
    w_stateNext   = r_state;
    w_idxNext     = r_stepIdx;
    w_pulseNext   = 1'b0;
    w_passNext    = r_pass;
    w_failNext    = r_fail;
    w_codeNext    = r_failCode;
    w_elapsedNext = r_elapsed;
    if (!en) begin
      w_stateNext   = IDLE;
      w_idxNext     = '0;
      w_passNext    = 1'b0;
      w_failNext    = 1'b0;
      w_codeNext    = FC_NONE;
      w_elapsedNext = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_stateNext   = WAIT;
          w_elapsedNext = EL_W'(1);
        end
        WAIT: begin
          if (r_elapsed != EL_W'(TIMEOUT_CYCLES)) begin
            w_elapsedNext = r_elapsed + 1'b1;
          end
          if (w_curHit) begin
            w_pulseNext = 1'b1;
            w_idxNext   = r_stepIdx + 1'b1;
            if (w_lastStep) begin
              w_stateNext = PASS;
              w_passNext  = 1'b1;
            end else if (w_timeUp) begin
              w_stateNext = FAIL;
              w_failNext  = 1'b1;
              w_codeNext  = FC_TIMEOUT;
            end
          end else if (w_orderHit) begin
            w_stateNext = FAIL;
            w_failNext  = 1'b1;
            w_codeNext  = FC_ORDER;
          end else if (w_timeUp) begin
            w_stateNext = FAIL;
            w_failNext  = 1'b1;
            w_codeNext  = FC_TIMEOUT;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stepIdx  <= '0;
      r_pulse    <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_failCode <= FC_NONE;
      r_elapsed  <= '0;
    end else begin
      r_stepIdx  <= w_idxNext;
      r_pulse    <= w_pulseNext;
      r_pass     <= w_passNext;
      r_fail     <= w_failNext;
      r_failCode <= w_codeNext;
      r_elapsed  <= w_elapsedNext;
    end
  end

  assign step_idx   = r_stepIdx;
  assign step_pulse = r_pulse;
  assign pass       = r_pass;
  assign fail       = r_fail;
  assign fail_code  = r_failCode;
  assign elapsed    = r_elapsed;

endmodule

// File: tb/tb_wfg_checkpoint_monitor.sv
// Bench for wfg_checkpoint_monitor: a lax and a strict instance share one
// stimulus stream; each driven row queues the outputs expected after its edge.
module tb_wfg_checkpoint_monitor;

  localparam int W  = 16;
  localparam int N  = 2;
  localparam int TO = 100;
  localparam int ST = 2;
  localparam int IW = $clog2(N + 1);
  localparam int EW = $clog2(TO + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [W-1:0]  status;
  logic [N*W-1:0] expSeq;

  logic [IW-1:0] aIdx, sIdx;
  logic          aPulse, sPulse, aPass, sPass, aFail, sFail;
  logic [1:0]    aCode, sCode;
  logic [EW-1:0] aEl, sEl;

  typedef struct {
    logic          chk;
    logic          pulse;
    logic          pass;
    logic          fail;
    logic [1:0]    code;
    logic [IW-1:0] idx;
    logic [EW-1:0] elapsed;
  } exp_t;

  typedef struct {
    exp_t a;
    exp_t s;
    int   scen;
    int   row;
  } sb_t;

  typedef struct {
    logic         en;
    logic [W-1:0] st;
    exp_t         e;
  } vec_t;

  sb_t  sbQ[$];
  vec_t tbl[15];
  int   compared   = 0;
  int   mismatched = 0;
  int   scen       = 0;
  int   row        = 0;

  always #5 clk = ~clk;

  wfg_checkpoint_monitor #(
    .WIDTH(W), .NUM_STEPS(N), .TIMEOUT_CYCLES(TO), .STABLE_CYCLES(ST), .STRICT(0)
  ) dutLax (
    .clk(clk), .rst_n(rst_n), .en(en), .status(status), .exp_seq(expSeq),
    .step_idx(aIdx), .step_pulse(aPulse), .pass(aPass), .fail(aFail),
    .fail_code(aCode), .elapsed(aEl)
  );

  wfg_checkpoint_monitor #(
    .WIDTH(W), .NUM_STEPS(N), .TIMEOUT_CYCLES(TO), .STABLE_CYCLES(ST), .STRICT(1)
  ) dutStrict (
    .clk(clk), .rst_n(rst_n), .en(en), .status(status), .exp_seq(expSeq),
    .step_idx(sIdx), .step_pulse(sPulse), .pass(sPass), .fail(sFail),
    .fail_code(sCode), .elapsed(sEl)
  );

  function automatic exp_t mk(input logic p, input logic ps, input logic f,
                              input int c, input int idx, input int el);
    exp_t r;
    r.chk = 1'b1; r.pulse = p; r.pass = ps; r.fail = f;
    r.code = 2'(c); r.idx = IW'(idx); r.elapsed = EW'(el);
    return r;
  endfunction

  function automatic vec_t mkv(input logic e, input logic [W-1:0] st, input exp_t ex);
    vec_t v;
    v.en = e; v.st = st; v.e = ex;
    return v;
  endfunction

  task automatic cmpOne(input string who, input exp_t e, input int sc, input int rw,
                        input logic p, input logic ps, input logic f, input logic [1:0] c,
                        input logic [IW-1:0] idx, input logic [EW-1:0] el);
    if (e.chk) begin
      compared++;
      if ({p, ps, f, c, idx, el} !== {e.pulse, e.pass, e.fail, e.code, e.idx, e.elapsed}) begin
        mismatched++;
        $display("[TB] FAIL %s s%0d.r%0d: got pulse=%b pass=%b fail=%b code=%0d idx=%0d elapsed=%0d, want pulse=%b pass=%b fail=%b code=%0d idx=%0d elapsed=%0d",
                 who, sc, rw, p, ps, f, c, idx, el,
                 e.pulse, e.pass, e.fail, e.code, e.idx, e.elapsed);
      end
    end
  endtask

  task automatic checkOutput(input sb_t e);
    cmpOne("lax", e.a, e.scen, e.row, aPulse, aPass, aFail, aCode, aIdx, aEl);
    cmpOne("strict", e.s, e.scen, e.row, sPulse, sPass, sFail, sCode, sIdx, sEl);
  endtask

  // Outputs seen at this negedge belong to the row driven one cycle earlier.
  task automatic applyStimulus(input logic r, input logic e, input logic [W-1:0] st,
                               input exp_t ea, input exp_t es);
    sb_t item;
    @(negedge clk);
    if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
    rst_n  = r;
    en     = e;
    status = st;
    item.a = ea; item.s = es; item.scen = scen; item.row = row;
    sbQ.push_back(item);
    row++;
  endtask

  task automatic newScenario(input int id);
    scen = id;
    row  = 0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t z, ex, exs;
    z      = mk(0, 0, 0, 0, 0, 0);
    rst_n  = 1'b0;
    en     = 1'b0;
    status = '0;
    expSeq = {16'hAB61, 16'hAB60};

    tbl[0]  = mkv(1, 16'h0000, mk(0, 0, 0, 0, 0, 1));
    tbl[1]  = mkv(1, 16'h0000, mk(0, 0, 0, 0, 0, 2));
    tbl[2]  = mkv(1, 16'h0000, mk(0, 0, 0, 0, 0, 3));
    tbl[3]  = mkv(1, 16'h0000, mk(0, 0, 0, 0, 0, 4));
    tbl[4]  = mkv(1, 16'h0000, mk(0, 0, 0, 0, 0, 5));
    tbl[5]  = mkv(1, 16'hAB60, mk(0, 0, 0, 0, 0, 6));
    tbl[6]  = mkv(1, 16'hAB60, mk(1, 0, 0, 0, 1, 7));
    tbl[7]  = mkv(1, 16'h0000, mk(0, 0, 0, 0, 1, 8));
    tbl[8]  = mkv(1, 16'h0000, mk(0, 0, 0, 0, 1, 9));
    tbl[9]  = mkv(1, 16'h0000, mk(0, 0, 0, 0, 1, 10));
    tbl[10] = mkv(1, 16'hAB61, mk(0, 0, 0, 0, 1, 11));
    tbl[11] = mkv(1, 16'hAB61, mk(1, 1, 0, 0, 2, 12));
    tbl[12] = mkv(1, 16'h0000, mk(0, 1, 0, 0, 2, 12));
    tbl[13] = mkv(1, 16'h0000, mk(0, 1, 0, 0, 2, 12));
    tbl[14] = mkv(0, 16'h0000, z);

    $display("[TB] reset");
    newScenario(0);
    applyStimulus(0, 0, '0, z, z);
    applyStimulus(0, 1, 16'hAB60, z, z);

    $display("[TB] ordered pass sequence");
    newScenario(1);
    for (int i = 0; i < 15; i++) applyStimulus(1, tbl[i].en, tbl[i].st, tbl[i].e, tbl[i].e);

    $display("[TB] timeout with status stuck on step 0 code");
    newScenario(2);
    applyStimulus(1, 1, 16'hAB60, mk(0, 0, 0, 0, 0, 1), mk(0, 0, 0, 0, 0, 1));
    for (int k = 1; k <= 101; k++) begin
      if (k == 1)      ex = mk(0, 0, 0, 0, 0, 2);
      else if (k == 2) ex = mk(1, 0, 0, 0, 1, 3);
      else if (k < 99) ex = mk(0, 0, 0, 0, 1, k + 1);
      else             ex = mk(0, 0, 1, 1, 1, 100);
      applyStimulus(1, 1, 16'hAB60, ex, ex);
    end
    applyStimulus(1, 0, '0, z, z);

    $display("[TB] later step first: strict order error, lax runs to timeout");
    newScenario(3);
    applyStimulus(1, 1, 16'h0000, mk(0, 0, 0, 0, 0, 1), mk(0, 0, 0, 0, 0, 1));
    applyStimulus(1, 1, 16'hAB61, mk(0, 0, 0, 0, 0, 2), mk(0, 0, 0, 0, 0, 2));
    applyStimulus(1, 1, 16'hAB61, mk(0, 0, 0, 0, 0, 3), mk(0, 0, 1, 2, 0, 3));
    for (int k = 3; k <= 101; k++) begin
      ex = (k < 99) ? mk(0, 0, 0, 0, 0, k + 1) : mk(0, 0, 1, 1, 0, 100);
      applyStimulus(1, 1, 16'h0000, ex, mk(0, 0, 1, 2, 0, 3));
    end
    applyStimulus(1, 0, '0, z, z);

    $display("[TB] one-cycle glitch, then disarm from WAIT");
    newScenario(4);
    applyStimulus(1, 1, 16'h0000, mk(0, 0, 0, 0, 0, 1), mk(0, 0, 0, 0, 0, 1));
    applyStimulus(1, 1, 16'hAB60, mk(0, 0, 0, 0, 0, 2), mk(0, 0, 0, 0, 0, 2));
    applyStimulus(1, 1, 16'h0000, mk(0, 0, 0, 0, 0, 3), mk(0, 0, 0, 0, 0, 3));
    applyStimulus(1, 1, 16'hAB60, mk(0, 0, 0, 0, 0, 4), mk(0, 0, 0, 0, 0, 4));
    applyStimulus(1, 1, 16'hAB60, mk(1, 0, 0, 0, 1, 5), mk(1, 0, 0, 0, 1, 5));
    applyStimulus(1, 0, 16'hAB61, z, z);

    $display("[TB] final completion on the timeout edge");
    newScenario(5);
    applyStimulus(1, 1, 16'h0000, mk(0, 0, 0, 0, 0, 1), mk(0, 0, 0, 0, 0, 1));
    for (int k = 1; k <= 100; k++) begin
      if (k == 1)       ex = mk(0, 0, 0, 0, 0, 2);
      else if (k == 2)  ex = mk(1, 0, 0, 0, 1, 3);
      else if (k < 99)  ex = mk(0, 0, 0, 0, 1, k + 1);
      else if (k == 99) ex = mk(1, 1, 0, 0, 2, 100);
      else              ex = mk(0, 1, 0, 0, 2, 100);
      applyStimulus(1, 1, (k <= 2) ? 16'hAB60 : ((k == 98 || k == 99) ? 16'hAB61 : 16'h0000), ex, ex);
    end
    applyStimulus(1, 0, '0, z, z);

    $display("[TB] order error on the timeout edge");
    newScenario(6);
    applyStimulus(1, 1, 16'h0000, mk(0, 0, 0, 0, 0, 1), mk(0, 0, 0, 0, 0, 1));
    for (int k = 1; k <= 100; k++) begin
      if (k < 99) begin
        ex = mk(0, 0, 0, 0, 0, k + 1);
        exs = ex;
      end else begin
        ex  = mk(0, 0, 1, 1, 0, 100);
        exs = mk(0, 0, 1, 2, 0, 100);
      end
      applyStimulus(1, 1, (k == 98 || k == 99) ? 16'hAB61 : 16'h0000, ex, exs);
    end
    applyStimulus(1, 0, '0, z, z);

    $display("[TB] duplicate consecutive codes need a drop-out");
    newScenario(7);
    expSeq = {16'hAB60, 16'hAB60};
    applyStimulus(1, 1, 16'h0000, mk(0, 0, 0, 0, 0, 1), mk(0, 0, 0, 0, 0, 1));
    applyStimulus(1, 1, 16'hAB60, mk(0, 0, 0, 0, 0, 2), mk(0, 0, 0, 0, 0, 2));
    applyStimulus(1, 1, 16'hAB60, mk(1, 0, 0, 0, 1, 3), mk(1, 0, 0, 0, 1, 3));
    applyStimulus(1, 1, 16'hAB60, mk(0, 0, 0, 0, 1, 4), mk(0, 0, 0, 0, 1, 4));
    applyStimulus(1, 1, 16'hAB60, mk(0, 0, 0, 0, 1, 5), mk(0, 0, 0, 0, 1, 5));
    applyStimulus(1, 1, 16'h0000, mk(0, 0, 0, 0, 1, 6), mk(0, 0, 0, 0, 1, 6));
    applyStimulus(1, 1, 16'hAB60, mk(0, 0, 0, 0, 1, 7), mk(0, 0, 0, 0, 1, 7));
    applyStimulus(1, 1, 16'hAB60, mk(1, 1, 0, 0, 2, 8), mk(1, 1, 0, 0, 2, 8));
    applyStimulus(1, 1, 16'h0000, mk(0, 1, 0, 0, 2, 8), mk(0, 1, 0, 0, 2, 8));
    applyStimulus(1, 0, '0, z, z);
    expSeq = {16'hAB61, 16'hAB60};

    $display("[TB] reset mid-sequence and clean restart");
    newScenario(8);
    applyStimulus(1, 1, 16'h0000, mk(0, 0, 0, 0, 0, 1), mk(0, 0, 0, 0, 0, 1));
    for (int k = 1; k <= 4; k++) begin
      ex = mk(0, 0, 0, 0, 0, k + 1);
      applyStimulus(1, 1, 16'h0000, ex, ex);
    end
    applyStimulus(1, 1, 16'hAB60, mk(0, 0, 0, 0, 0, 6), mk(0, 0, 0, 0, 0, 6));
    applyStimulus(1, 1, 16'hAB60, mk(1, 0, 0, 0, 1, 7), mk(1, 0, 0, 0, 1, 7));
    applyStimulus(1, 1, 16'hAB61, mk(0, 0, 0, 0, 1, 8), mk(0, 0, 0, 0, 1, 8));
    applyStimulus(0, 1, 16'hAB61, z, z);
    applyStimulus(1, 0, 16'hAB61, z, z);
    applyStimulus(1, 1, 16'hAB61, mk(0, 0, 0, 0, 0, 1), mk(0, 0, 0, 0, 0, 1));
    applyStimulus(1, 1, 16'hAB60, mk(0, 0, 0, 0, 0, 2), mk(0, 0, 0, 0, 0, 2));
    applyStimulus(1, 1, 16'hAB60, mk(1, 0, 0, 0, 1, 3), mk(1, 0, 0, 0, 1, 3));
    applyStimulus(1, 1, 16'hAB61, mk(0, 0, 0, 0, 1, 4), mk(0, 0, 0, 0, 1, 4));
    applyStimulus(1, 1, 16'hAB61, mk(1, 1, 0, 0, 2, 5), mk(1, 1, 0, 0, 2, 5));

    @(negedge clk);
    while (sbQ.size() > 0) checkOutput(sbQ.pop_front());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wfg_checkpoint_monitor.md
# wfg_checkpoint_monitor

Parametrised checkpoint sequencer for the WFG verification environment. It watches a WIDTH-bit status bus (firmware checkpoint bits driven on the user I/O pads) for an ordered sequence of NUM_STEPS expected codes, each held stable for STABLE_CYCLES. It flags pass, timeout or out-of-order failure. It replaces hard-coded wait/timeout logic in port-level benches with one synthesisable, reusable checker instantiated beside the Caravel model.

## Interface
- WIDTH, 16: status bus width.
- NUM_STEPS, 2: number of checkpoints in the sequence (1..16).
- TIMEOUT_CYCLES, 70000: global cycle budget from arm to final checkpoint (>=1).
- STABLE_CYCLES, 1: consecutive cycles a code must match before it counts (>=1).
- STRICT, 0: 1 = a stable match on any later step fails with ORDER.

- clk  in  1  monitor clock
- rst_n  in  1  synchronous, active-low reset
- en  in  1  arm; level-sensitive, 0 returns to IDLE
- status  in  WIDTH  observed checkpoint bus
- exp_seq  in  NUM_STEPS*WIDTH  expected codes, step k at bits [k*WIDTH +: WIDTH]
- step_idx  out  $clog2(NUM_STEPS+1)  checkpoints completed so far
- step_pulse  out  1  one-cycle strobe per completed checkpoint
- pass  out  1  sticky, all steps matched
- fail  out  1  sticky, timeout or order error
- fail_code  out  2  0 NONE, 1 TIMEOUT, 2 ORDER
- elapsed  out  $clog2(TIMEOUT_CYCLES+1)  cycles spent in WAIT, frozen on PASS/FAIL

## Operation
- States: IDLE, WAIT, PASS, FAIL.
- IDLE: counters cleared, outputs 0; en=1 -> WAIT on the next edge.
- WAIT, every cycle:
  - elapsed increments by 1.
  - If status == exp_seq[step_idx], stab_cnt increments; otherwise stab_cnt clears.
  - When stab_cnt reaches STABLE_CYCLES: step_pulse=1, step_idx++, stab_cnt clears. On the last step -> PASS.
  - STRICT=1 only: status matching exp_seq[j] for some j>step_idx, stable STABLE_CYCLES (separate order counter), -> FAIL, fail_code=ORDER.
  - elapsed == TIMEOUT_CYCLES-1 with no final completion -> FAIL, fail_code=TIMEOUT.
- Simultaneous events in the same cycle, in priority order:
  - Final completion beats timeout.
  - Completion of the current step beats order error.
  - Order error beats timeout.
- Duplicate codes: exp_seq[k]==exp_seq[k+1] requires the code to drop out of match and return; step k+1 matching is armed only after one non-matching cycle.
- PASS/FAIL: hold; pass/fail/fail_code/elapsed/step_idx frozen; no further step_pulse.
- en=0 in any state -> IDLE next edge, all outputs cleared.
- exp_seq is sampled combinationally. It must be static while en=1; changes while armed are undefined.

## Timing
- Reset (rst_n=0 at edge): state IDLE; step_idx, step_pulse, pass, fail, fail_code, elapsed all 0.
- Arm latency: en high at edge N -> WAIT from N+1; first compare cycle N+1.
- Match latency: status matching from edge M, held through STABLE_CYCLES edges -> step_pulse high during cycle M+STABLE_CYCLES, exactly one cycle.
- pass rises in the same cycle as the final step_pulse.
- fail rises one cycle after the cycle where elapsed reached TIMEOUT_CYCLES-1.
- elapsed saturates at TIMEOUT_CYCLES and never wraps.
- Reset mid-sequence overrides everything and clears all outputs.

## Structure
- Package wfg_mon_pkg holds:
  - state enum IDLE/WAIT/PASS/FAIL;
  - fail_code localparams FC_NONE/FC_TIMEOUT/FC_ORDER.
- Sub-module wfg_stable_match:
  - one comparator plus stability counter;
  - instantiated once for the current step, plus one for the OR of later-step matches when STRICT=1.
- Expected RTL size: ~200 lines.

## Test plan
- WIDTH=16, NUM_STEPS=2, exp={16'hAB61,16'hAB60}, STABLE=2, TIMEOUT=100, en at cycle 0, AB60 at cycles 5-6, AB61 at 10-11 -> step_pulse at 7 and 12, pass=1 from 12, step_idx=2, elapsed frozen at 12.
- Same config, status stuck at AB60 -> one step_pulse, fail=1 with fail_code=1 at cycle 100, elapsed=100.
- STRICT=1, status AB61 for 2 cycles before any AB60 -> fail, fail_code=2, step_idx=0. Same stimulus with STRICT=0 -> no fail until timeout.
- Glitch: AB60 for 1 cycle only with STABLE=2 -> no step_pulse, stab_cnt cleared.
- Final match completing on cycle 99 with TIMEOUT=100 -> pass=1, fail=0.
- rst_n low at cycle 8, mid-sequence -> all outputs 0 next edge. en toggled 0->1 -> clean restart, elapsed counts from 0.
